// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP port arbiter slice.
// Image geometry, FSM states and the buffered result entry.
package lbp_pkg;

    localparam int IMG_DIM = 128;
    localparam int ADDR_W  = 2 * $clog2(IMG_DIM);
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/lbp_wr_fifo.sv
// Small synchronous FIFO buffering engine results before the host write port.
// A push is accepted when full only if a pop happens in the same cycle.
module lbp_wr_fifo
    import lbp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t pop_entry,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign pop_entry = mem[rd_ptr];

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lbp_port_arbiter.sv
// Shares the host read port and result write port between two LBP engines.
// Sequences start-up, round-robin arbitrates both ports and raises finish.
module lbp_port_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [DATA_W-1:0] lbp_data,
    output logic              finish,
    output logic              s0_start,
    input  logic              s0_rd_req,
    input  logic [ADDR_W-1:0] s0_rd_addr,
    output logic              s0_rd_gnt,
    output logic              s0_rd_valid,
    output logic [DATA_W-1:0] s0_rd_data,
    input  logic              s0_wr_valid,
    input  logic [ADDR_W-1:0] s0_wr_addr,
    input  logic [DATA_W-1:0] s0_wr_data,
    output logic              s0_wr_ack,
    input  logic              s0_done,
    output logic              s1_start,
    input  logic              s1_rd_req,
    input  logic [ADDR_W-1:0] s1_rd_addr,
    output logic              s1_rd_gnt,
    output logic              s1_rd_valid,
    output logic [DATA_W-1:0] s1_rd_data,
    input  logic              s1_wr_valid,
    input  logic [ADDR_W-1:0] s1_wr_addr,
    input  logic [DATA_W-1:0] s1_wr_data,
    output logic              s1_wr_ack,
    input  logic              s1_done
);

    import lbp_pkg::*;

    state_t            state;
    logic [1:0]        done_q;
    logic              start_q;
    logic              rd_last;
    logic              wr_last;
    logic              rd_owner;
    logic [DATA_W-1:0] rd_data_q;
    logic              run;
    logic              wr_en;
    logic              wr_room;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    wr_entry_t         push_entry;
    wr_entry_t         pop_entry;

    assign run         = (state == RUN);
    assign wr_en       = (state == RUN) || (state == DRAIN);
    assign pop         = !empty;
    assign wr_room     = !full || pop;
    assign push        = s0_wr_ack || s1_wr_ack;
    assign s0_start    = start_q;
    assign s1_start    = start_q;
    assign s0_rd_data  = rd_data_q;
    assign s1_rd_data  = rd_data_q;

    // Read grant: tie goes to the engine not served last
    always_comb begin
        s0_rd_gnt = 1'b0;
        s1_rd_gnt = 1'b0;
        if (run) begin
            if (s0_rd_req && s1_rd_req) begin
                s0_rd_gnt = rd_last;
                s1_rd_gnt = !rd_last;
            end else begin
                s0_rd_gnt = s0_rd_req;
                s1_rd_gnt = s1_rd_req;
            end
        end
    end

    // Write ack: independent round-robin, gated by FIFO room
    always_comb begin
        s0_wr_ack = 1'b0;
        s1_wr_ack = 1'b0;
        if (wr_en && wr_room) begin
            if (s0_wr_valid && s1_wr_valid) begin
                s0_wr_ack = wr_last;
                s1_wr_ack = !wr_last;
            end else begin
                s0_wr_ack = s0_wr_valid;
                s1_wr_ack = s1_wr_valid;
            end
        end
    end

    // Entry from whichever engine won the write port
    always_comb begin
        if (s1_wr_ack) begin
            push_entry = '{addr: s1_wr_addr, data: s1_wr_data};
        end else begin
            push_entry = '{addr: s0_wr_addr, data: s0_wr_data};
        end
    end

    lbp_wr_fifo #(
        .DEPTH(WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .pop_entry (pop_entry),
        .full      (full),
        .empty     (empty)
    );

    // Two-stage read pipeline: host request, then data return to owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_req    <= 1'b0;
            gray_addr   <= '0;
            rd_owner    <= 1'b0;
            rd_last     <= 1'b1;
            s0_rd_valid <= 1'b0;
            s1_rd_valid <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            gray_req <= s0_rd_gnt || s1_rd_gnt;
            if (s0_rd_gnt || s1_rd_gnt) begin
                gray_addr <= s1_rd_gnt ? s1_rd_addr : s0_rd_addr;
                rd_owner  <= s1_rd_gnt;
                rd_last   <= s1_rd_gnt;
            end
            s0_rd_valid <= gray_req && !rd_owner;
            s1_rd_valid <= gray_req && rd_owner;
            if (gray_req) begin
                rd_data_q <= gray_data;
            end
        end
    end

    // Write pointer update and registered result port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_last   <= 1'b1;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
        end else begin
            if (push) begin
                wr_last <= s1_wr_ack;
            end
            lbp_valid <= pop;
            if (pop) begin
                lbp_addr <= pop_entry.addr;
                lbp_data <= pop_entry.data;
            end
        end
    end

    // Sequencing FSM with sticky done flags and registered start/finish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            done_q  <= 2'b00;
            start_q <= 1'b0;
            finish  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gray_ready) begin
                        state   <= RUN;
                        start_q <= 1'b1;
                    end
                end
                RUN: begin
                    done_q <= done_q | {s1_done, s0_done};
                    if (&done_q) begin
                        state   <= DRAIN;
                        start_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (empty && !gray_req && !push) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lbp_port_arbiter.md
# lbp_port_arbiter

Shares the single host grayscale read port and the single LBP result write port between two LBP engines (engine 0 and engine 1) so that each processes half of the 128x128 image in parallel. It sits between the host/testbench memory interface and the two engines, sequences start-up from the host `gray_ready`, and raises one global `finish` once both engines are done and all results have been written.

## Interface
- ADDR_W, 14, pixel address width ({row[6:0], col[6:0]})
- DATA_W, 8, pixel / LBP data width
- WFIFO_DEPTH, 2, result write buffer depth (power of 2, >= 2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- gray_ready  in  1  host memory ready
- gray_req  out  1  host read request (registered)
- gray_addr  out  ADDR_W  host read address (registered)
- gray_data  in  DATA_W  host read data, valid in the cycle `gray_addr` and `gray_req` are presented
- lbp_valid  out  1  result write strobe (registered, 1-cycle pulse per result)
- lbp_addr  out  ADDR_W  result address
- lbp_data  out  DATA_W  result data
- finish  out  1  sticky completion flag
- sK_start  out  1  K∈{0,1}: engine enable, high in RUN
- sK_rd_req  in  1  engine read request; held with address until granted
- sK_rd_addr  in  ADDR_W  engine read address
- sK_rd_gnt  out  1  combinational grant, same cycle
- sK_rd_valid  out  1  read data valid pulse
- sK_rd_data  out  DATA_W  read data
- sK_wr_valid  in  1  engine result valid; held with address/data until acked
- sK_wr_addr  in  ADDR_W  result address
- sK_wr_data  in  DATA_W  result data
- sK_wr_ack  out  1  combinational accept, same cycle
- sK_done  in  1  engine finished (level or pulse)

## Operation
- FSM: IDLE -> RUN when `gray_ready`=1; RUN -> DRAIN when both done flags are latched; DRAIN -> DONE when the write FIFO is empty and no read is in flight; DONE is terminal until reset.
- Done flags: `sK_done` is latched sticky (`done_q[K]`) in RUN and cleared only by reset.
- Read arbitration happens in RUN only:
  - Round-robin with pointer `rd_last`. If both engines request, grant the one that is not `rd_last`. A single requester is always granted.
  - At most one grant per cycle. The grant updates `rd_last`.
- Write arbitration happens in RUN and DRAIN:
  - Round-robin with independent pointer `wr_last`.
  - An ack is issued only if the FIFO is not full or a pop happens in the same cycle.
  - The losing engine sees ack=0 and holds its request.
- FIFO pops one entry per cycle whenever it is non-empty. Popped entries drive `lbp_valid`/`lbp_addr`/`lbp_data` on the next edge.
- No address checking, reordering or modification of data.
- Reset mid-operation: every register returns to its reset value immediately. In-flight reads and buffered results are discarded. The host must restart.

## Timing
- Reset values:
  - 0: `gray_req`, `gray_addr`, `lbp_valid`, `lbp_addr`, `lbp_data`, `finish`, `sK_start`, `sK_rd_valid`, `sK_rd_data`.
  - `rd_last` and `wr_last` = 1, so engine 0 wins the first tie.
  - FIFO empty.
- Read path, with the grant in cycle T:
  - T+1: `gray_req`=1, `gray_addr`=granted address, host returns `gray_data`.
  - T+2: `sK_rd_valid`=1 for the granted K with `sK_rd_data` = `gray_data` sampled at end of T+1.
  - Grant-to-data latency is exactly 2 cycles.
  - Back-to-back grants sustain 1 read/cycle.
  - Idle cycles: `gray_req`=0, `gray_addr` holds.
- Write path: ack in cycle T -> push at end of T -> if the FIFO was empty, `lbp_valid` in T+2. Sustains 1 result/cycle.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- `sK_start` rises one cycle after `gray_ready` is sampled high in IDLE.
- `finish` rises on the edge entering DONE and stays high.
- `sK_start` falls on the edge leaving RUN.

## Structure
- Shared package `lbp_pkg`:
  - ADDR_W, DATA_W, IMG_DIM=128.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Write-entry struct {addr, data}.
- One sub-module, `lbp_wr_fifo`: synchronous FIFO of write entries with full/empty flags and async reset.
- Read tracking lives in the top level: a 2-stage valid/owner shift register.

## Test plan
- Reset held, then `gray_ready`=1 -> all outputs 0 during reset; `sK_start`=1 one cycle after release plus sample; `finish`=0.
- Engine 0 alone requests addr 0x0081 with host data 0x5A -> `s0_rd_gnt` same cycle; `gray_addr`=0x0081 next cycle; `s0_rd_valid`=1, `s0_rd_data`=0x5A two cycles after grant; `s1_rd_valid` stays 0.
- Both engines request continuously (0x0081, 0x2081) -> grants alternate 0,1,0,1 starting with engine 0; `gray_req` high every cycle; each engine receives the correct data.
- Both engines assert write in the same cycle ({0x0101,0xAA}, {0x2101,0x55}) -> engine 0 acked first, engine 1 acked next cycle; `lbp_valid` pulses emit 0x0101/0xAA then 0x2101/0x55 in consecutive cycles.
- `s0_done` pulses, then `s1_done` while one result is still buffered -> DRAIN until the FIFO is empty; `finish`=1 the cycle after the last `lbp_valid` and stays high.
- Reset asserted in RUN with a read in flight and the FIFO non-empty -> no `sK_rd_valid` or `lbp_valid` after reset; state IDLE; `finish`=0.
